matrix_activation: RTL
======================

# matrix_activation

Element-wise activation engine placed downstream of the matrix multiplication and convolution engines in the AI accelerator. It reads a job header and a result vector from the shared 256-word SRAM, applies ReLU, int8 saturation or leaky ReLU to each signed 32-bit element, and writes each result back in place. It attaches to the accelerator top's memory controller with the same `mem_operation` / `mem_opdone` handshake as the other engines, and the top selects it with operation code 3.

## Interface
- `HDR_ADDR`, 32'h0: SRAM word address of the header. Word `HDR_ADDR` holds count N; word `HDR_ADDR+1` holds function code F; data occupies `HDR_ADDR+2` to `HDR_ADDR+1+N`.
- `MAX_COUNT`, 254: upper clamp applied to N.
- `LEAKY_SHIFT`, 3: arithmetic right-shift amount used for negative inputs under leaky ReLU.
- `clk`, input, 1: system clock, driven by `wb_clk_i`. Single clock domain.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: starts and holds a job while high.
- `done`, output, 1: job complete. Held until `enable` falls.
- `addr_o`, output, 32: SRAM word address of the current request.
- `data_i`, input, 32: SRAM read data. Valid in the cycle `mem_opdone` is high for a read.
- `data_o`, output, 32: write data.
- `mem_opdone`, input, 1: one-cycle completion pulse from the memory controller.
- `mem_operation`, output, 2: request code. 00 = none, 01 = read, 11 = write.

## Operation
- States: IDLE, RD_CNT, RD_FN, RD_EL, CALC, WR_EL, GAP, FIN.
- IDLE to RD_CNT on `enable` high. A job samples `HDR_ADDR`; index i is set to 0.
- Each RD_* or WR_EL state drives `mem_operation` and `addr_o` (plus `data_o` for writes) constant until `mem_opdone` is sampled high.
- RD_CNT: on opdone, N is set to min(`data_i`, `MAX_COUNT`), with `data_i` treated as unsigned.
- RD_FN: on opdone, F is set to `data_i[1:0]`. If N = 0 the next state is FIN, otherwise RD_EL.
- RD_EL: address is `HDR_ADDR+2+i`. On opdone, `data_i` is latched into x.
- CALC: one cycle. y = act(x, F).
- WR_EL: address is `HDR_ADDR+2+i` and `data_o` = y. On opdone, i increments.
- GAP: every opdone is followed by exactly one cycle with `mem_operation` = 00. This keeps the controller's opdone-clear cycle from consuming a request. GAP then advances to the pending next state: RD_FN, RD_EL/FIN after the header, CALC after RD_EL, or RD_EL/FIN after WR_EL. FIN is taken when i = N.
- FIN: `done` = 1 and `mem_operation` = 00. FIN goes to IDLE when `enable` is low.
- act, with signed 32-bit input and output:
  - F=0, ReLU: x<0 gives 0, otherwise x.
  - F=1, int8 saturation: clamps x to [-128, 127].
  - F=2, leaky ReLU: x<0 gives x>>>`LEAKY_SHIFT`, otherwise x. Therefore -1 maps to -1.
  - F=3, identity: y = x, and the write still occurs.
- `enable` falling mid-job:
  - With a request outstanding, the engine holds the request until opdone, then goes to IDLE with no further requests.
  - With no request outstanding, the engine goes to IDLE on the next cycle.
  - `done` stays 0 in both cases.
- `enable` rising in the same cycle as reset: reset wins.
- Addresses wrap modulo 2^32. The top truncates them to the SRAM width.

## Timing
- Reset values: `done` = 0, `mem_operation` = 00, `addr_o` = 0, `data_o` = 0, state = IDLE.
- The first read request is visible 1 cycle after `enable` is sampled high.
- Engine overhead per transfer is 1 GAP cycle. Each element additionally costs 1 CALC cycle. Per-element cost is therefore 2 transfers + 3 engine cycles + the controller latency.
- `done` rises 1 cycle after the last write's GAP cycle, or after the GAP following RD_FN when N = 0.
- `done` falls 1 cycle after `enable` is sampled low.
- `mem_operation` never changes between request assertion and opdone.

## Structure
- Shared package holds:
  - `TYPE_BW` = 32.
  - Memory op codes: `MEM_NONE` = 2'b00, `MEM_READ` = 2'b01, `MEM_WRITE` = 2'b11.
  - Activation codes: `ACT_RELU` = 0, `ACT_SAT8` = 1, `ACT_LEAKY` = 2, `ACT_IDENT` = 3.
  - Top operation code `OP_ACT` = 3.
- Sub-module `act_alu`: purely combinational act(x, F, `LEAKY_SHIFT`). It is reused by future fused paths.
- The top adds a case for operation 3 in its memory arbiter and in its control unit, mirroring the existing engines.

## Test plan
- ReLU: header N=4, F=0; data {5, -3, 0, -2147483648}. Required SRAM result: {5, 0, 0, 0}, `done` = 1, and exactly 2+8 transfers.
- Saturation: N=3, F=1; data {300, -129, 77}. Required result: {127, -128, 77}.
- Leaky ReLU (`LEAKY_SHIFT` = 3): N=3, F=2; data {-16, -1, 9}. Required result: {-2, -1, 9}.
- N=0, then N=1000: with N=0, `done` follows the header reads with no data access. With N=1000, exactly 254 elements are written and the word at `HDR_ADDR+256` (mod 256) is untouched.
- Abort: drop `enable` while RD_EL is pending with a controller latency of 5 cycles. Required: the request is held until opdone, no write follows, the engine returns to IDLE, `done` stays 0, and a restarted job completes correctly.
- Handshake check: an assertion that `mem_operation` is stable until opdone and that a 00 cycle follows every opdone. Also assert reset mid-WR_EL gives all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/matrix_activation_pkg.sv
// Shared definitions for the activation engine: data width, memory request
// codes, activation function codes, the accelerator-top operation code and
// the engine state type.
package matrix_activation_pkg;

  localparam int unsigned TYPE_BW = 32;

  // Memory controller request codes
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  // Activation function codes (low two bits of the header F word)
  localparam logic [1:0] ACT_RELU  = 2'd0;
  localparam logic [1:0] ACT_SAT8  = 2'd1;
  localparam logic [1:0] ACT_LEAKY = 2'd2;
  localparam logic [1:0] ACT_IDENT = 2'd3;

  // Operation code used by the accelerator top to select this engine
  localparam int unsigned OP_ACT = 3;

  typedef enum logic [2:0] {
    StIdle,
    StRdCnt,
    StRdFn,
    StRdEl,
    StCalc,
    StWrEl,
    StGap,
    StFin
  } act_state_e;

endpackage

// File: rtl/matrix_activation_alu.sv
// act_alu: purely combinational element-wise activation on a signed word.
// Ports:
//   x_i  - signed input element
//   fn_i - activation code (ReLU, int8 saturation, leaky ReLU, identity)
//   y_o  - signed result
module act_alu
  import matrix_activation_pkg::*;
#(
  parameter int unsigned LEAKY_SHIFT = 3
) (
  input  logic [TYPE_BW-1:0] x_i,
  input  logic [1:0]         fn_i,
  output logic [TYPE_BW-1:0] y_o
);

  logic signed [TYPE_BW-1:0] xs;
  assign xs = signed'(x_i);

  always_comb begin
    y_o = x_i;
    unique case (fn_i)
      ACT_RELU: begin
        if (xs < 0) y_o = '0;
      end
      ACT_SAT8: begin
        if (xs > 32'sd127)       y_o = 32'd127;
        else if (xs < -32'sd128) y_o = 32'hFFFF_FF80;
      end
      ACT_LEAKY: begin
        // Arithmetic shift floors toward -inf, so -1 stays -1
        if (xs < 0) y_o = xs >>> LEAKY_SHIFT;
      end
      default: ; // identity
    endcase
  end

endmodule

// File: rtl/matrix_activation.sv
// matrix_activation: reads a header (count N, function F) and N elements from
// the shared SRAM, applies the selected activation and writes each result back
// in place. Uses the mem_operation / mem_opdone handshake of the other engines.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   enable         - starts and holds a job while high
//   done           - job complete, held until enable falls
//   addr_o, data_o - request address and write data
//   data_i         - read data, valid while mem_opdone is high
//   mem_opdone     - one-cycle completion pulse from the controller
//   mem_operation  - request code (none / read / write)
module matrix_activation
  import matrix_activation_pkg::*;
#(
  parameter logic [TYPE_BW-1:0] HDR_ADDR    = 32'h0,
  parameter int unsigned        MAX_COUNT   = 254,
  parameter int unsigned        LEAKY_SHIFT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic               done,
  output logic [TYPE_BW-1:0] addr_o,
  input  logic [TYPE_BW-1:0] data_i,
  output logic [TYPE_BW-1:0] data_o,
  input  logic               mem_opdone,
  output logic [1:0]         mem_operation
);

  localparam int unsigned CntW = $clog2(MAX_COUNT + 1);

  act_state_e           state_q, state_d, pend_q, pend_d;
  logic [CntW-1:0]      cnt_q, cnt_d, idx_q, idx_d;
  logic [1:0]           fn_q, fn_d;
  logic [TYPE_BW-1:0]   x_q, x_d, y_q, y_d;
  logic                 abort_q, abort_d;
  logic                 abort_now;
  logic [TYPE_BW-1:0]   el_addr;
  logic [TYPE_BW-1:0]   y_alu;

  act_alu #(
    .LEAKY_SHIFT(LEAKY_SHIFT)
  ) u_act_alu (
    .x_i (x_q),
    .fn_i(fn_q),
    .y_o (y_alu)
  );

  assign el_addr   = HDR_ADDR + 32'd2 + TYPE_BW'(idx_q);
  // Once enable drops with a request in flight, finish that request and stop
  assign abort_now = abort_q | ~enable;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    fn_d          = fn_q;
    x_d           = x_q;
    y_d           = y_q;
    abort_d       = abort_q;
    done          = 1'b0;
    mem_operation = MEM_NONE;
    addr_o        = '0;
    data_o        = '0;

    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (enable) begin
          state_d = StRdCnt;
          idx_d   = '0;
        end
      end
      StRdCnt: begin
        mem_operation = MEM_READ;
        addr_o        = HDR_ADDR;
        if (!enable) abort_d = 1'b1;
        if (mem_opdone) begin
          cnt_d   = (data_i > TYPE_BW'(MAX_COUNT)) ? CntW'(MAX_COUNT) : data_i[CntW-1:0];
          pend_d  = StRdFn;
          state_d = abort_now ? StIdle : StGap;
        end
      end
      StRdFn: begin
        mem_operation = MEM_READ;
        addr_o        = HDR_ADDR + 32'd1;
        if (!enable) abort_d = 1'b1;
        if (mem_opdone) begin
          fn_d    = data_i[1:0];
          pend_d  = (cnt_q == '0) ? StFin : StRdEl;
          state_d = abort_now ? StIdle : StGap;
        end
      end
      StRdEl: begin
        mem_operation = MEM_READ;
        addr_o        = el_addr;
        if (!enable) abort_d = 1'b1;
        if (mem_opdone) begin
          x_d     = data_i;
          pend_d  = StCalc;
          state_d = abort_now ? StIdle : StGap;
        end
      end
      StCalc: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          y_d     = y_alu;
          state_d = StWrEl;
        end
      end
      StWrEl: begin
        mem_operation = MEM_WRITE;
        addr_o        = el_addr;
        data_o        = y_q;
        if (!enable) abort_d = 1'b1;
        if (mem_opdone) begin
          idx_d   = idx_q + CntW'(1);
          pend_d  = ((idx_q + CntW'(1)) == cnt_q) ? StFin : StRdEl;
          state_d = abort_now ? StIdle : StGap;
        end
      end
      StGap: begin
        // Idle cycle so the controller's opdone-clear cycle sees no request
        state_d = enable ? pend_q : StIdle;
      end
      StFin: begin
        done = 1'b1;
        if (!enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pend_q  <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      fn_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fn_q    <= fn_d;
      x_q     <= x_d;
      y_q     <= y_d;
      abort_q <= abort_d;
    end
  end

endmodule
